bcd_countdown_timer: RTL
========================

Name: bcd_countdown_timer

Overview:
- Three-digit BCD down-counter (000–999): the counting-down counterpart of the team's up-counting decimal counter.
- Loads a preset value from board switches, decrements once per prescaled tick while running, then stops at 000 with a one-cycle done pulse.
- Digit outputs feed the existing seven-segment decoders.
- Sits between switch/key debouncers and the display path.

Parameters:
TICK_DIV, 10000000, clock cycles per decrement; legal range 1 to 2^32-1; prescaler width = $clog2(TICK_DIV), minimum 1 bit.

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_load  input  1  level; copy load digits into counter, go to IDLE
i_load_units  input  4  preset units digit
i_load_tens  input  4  preset tens digit
i_load_hundreds  input  4  preset hundreds digit
i_start  input  1  level; begin or resume counting
i_pause  input  1  level; suspend counting
o_units  output  4  current units digit, BCD
o_tens  output  4  current tens digit, BCD
o_hundreds  output  4  current hundreds digit, BCD
o_running  output  1  high while state is RUN
o_done  output  1  one-cycle pulse on reaching 000
o_zero  output  1  high whenever all digits are 0

Behaviour:
- Reset:
  - state IDLE; digits 000; prescaler 0.
  - o_running=0, o_done=0, o_zero=1.
  - i_rst overrides every other input in every state, including mid-RUN.
- Priority, highest first: i_rst > i_load > i_pause > i_start > tick.
- Load:
  - Any state: each load digit >9 is clamped to 9 and registered.
  - Prescaler cleared; next state IDLE; o_done not asserted.
  - Loaded value is visible on outputs the cycle after the edge.
- States:
  - IDLE:
    - i_start=1, i_pause=0, value≠000 → RUN with prescaler cleared.
    - i_start=1, i_pause=0, value=000 → DONE; o_done pulses.
  - RUN:
    - Prescaler increments each cycle.
    - When prescaler = TICK_DIV-1: prescaler wraps to 0 and the value decrements by one.
    - Decrement that yields 000 → DONE; o_done=1 in the same cycle the outputs first show 000; o_running=0 from that cycle.
    - i_pause=1 → PAUSE; prescaler and digits hold; a tick coincident with pause is suppressed.
  - PAUSE:
    - Prescaler retained.
    - i_start=1, i_pause=0 → RUN; counting resumes from the held prescaler value, so total run cycles stay exact.
    - i_start and i_pause both high → stay in PAUSE.
  - DONE:
    - Digits hold 000; i_start ignored; only i_load or i_rst leaves.
- Decrement arithmetic (BCD borrow chain):
  - units>0 → units-1.
  - else units=9 and borrow into tens: tens>0 → tens-1, else tens=9 and borrow into hundreds (hundreds-1).
  - 000 is never decremented; no wrap to 999.
- Output timing:
  - o_done is registered and high for exactly one cycle per completion.
  - o_running is registered (state==RUN).
  - o_zero is combinational from the digit registers.
- TICK_DIV=1: one decrement every RUN cycle.

Test Plan:
- Reset: assert i_rst 2 cycles → digits 000, o_zero=1, o_running=0, o_done=0; start with no load → DONE and a single o_done pulse, no further pulses.
- TICK_DIV=4, load 0/0/3, start → value 002, 001, 000 at 4-cycle spacing; o_done=1 exactly one cycle, coincident with the first 000; o_running falls in that cycle.
- TICK_DIV=4, load 1/0/0, start → after 4 cycles 099 (double borrow); after 8 cycles 098.
- TICK_DIV=4, load 0/1/0, start, pause after 2 run cycles for 10 cycles, resume → first decrement (009) 2 cycles after resume; outputs unchanged during pause; pause asserted on a tick cycle → no decrement.
- Load digits 0xF/0xA/0xC → outputs 9/9/9; i_load during RUN at 050 with preset 0/0/7 → IDLE at 007, no o_done.
- i_rst mid-RUN at 123 → next cycle 000, IDLE, o_done=0; subsequent load/start behaves normally.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// Three-digit BCD down-counter (000-999) with a switch-loaded preset and a
// prescaled decrement tick. Counting stops at 000 and o_done pulses for one cycle.
// Digit index 0 = units, 1 = tens, 2 = hundreds throughout.
module bcd_countdown_timer #(
  parameter int unsigned TICK_DIV = 10000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_load_units,
  input  logic [3:0] i_load_tens,
  input  logic [3:0] i_load_hundreds,
  input  logic       i_start,
  input  logic       i_pause,
  output logic [3:0] o_units,
  output logic [3:0] o_tens,
  output logic [3:0] o_hundreds,
  output logic       o_running,
  output logic       o_done,
  output logic       o_zero
);

  // Prescaler is at least one bit wide so TICK_DIV=1 still elaborates cleanly.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      digit_q [3];
  logic [3:0]      digit_d [3];
  logic            done_q, done_d;
  logic            running_q, running_d;

  logic [3:0]      load_raw [3];
  logic [3:0]      load_clamped [3];
  logic [3:0]      dec_digit [3];
  logic            zero_w;
  logic            dec_zero_w;

  assign load_raw[0] = i_load_units;
  assign load_raw[1] = i_load_tens;
  assign load_raw[2] = i_load_hundreds;

  // Switches can present 0xA-0xF; saturate each preset digit to 9.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_clamp
      assign load_clamped[gi] = (load_raw[gi] > 4'd9) ? 4'd9 : load_raw[gi];
    end
  endgenerate

  // Current value is 000 whenever every digit register is zero.
  assign zero_w = (digit_q[0] == 4'd0) && (digit_q[1] == 4'd0) && (digit_q[2] == 4'd0);

  // Value minus one via a BCD borrow chain; only applied when the value is nonzero.
  always_comb begin
    logic borrow;
    borrow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dec_digit[i] = digit_q[i];
      if (borrow) begin
        if (digit_q[i] != 4'd0) begin
          dec_digit[i] = digit_q[i] - 4'd1;
          borrow       = 1'b0;
        end else begin
          dec_digit[i] = 4'd9;
        end
      end
    end
  end

  assign dec_zero_w = (dec_digit[0] == 4'd0) && (dec_digit[1] == 4'd0) &&
                      (dec_digit[2] == 4'd0);

  // Next-state logic: load beats pause beats start beats the prescaler tick.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    digit_d = digit_q;
    done_d  = 1'b0;

    if (i_load) begin
      digit_d = load_clamped;
      presc_d = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start && !i_pause) begin
            if (zero_w) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
              presc_d = '0;
            end
          end
        end
        S_RUN: begin
          if (i_pause) begin
            // A tick landing on the pause cycle is dropped; prescaler holds.
            state_d = S_PAUSE;
          end else if (presc_q == TICK_LAST) begin
            presc_d = '0;
            if (!zero_w) begin
              digit_d = dec_digit;
              if (dec_zero_w) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end else begin
              state_d = S_DONE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSE: begin
          // Prescaler is kept so the resumed interval completes the partial tick.
          if (i_start && !i_pause) begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          // Held at 000 until a load or reset.
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    running_d = (state_d == S_RUN);
  end

  // State, prescaler, digit and registered status flops with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        digit_q[i] <= 4'd0;
      end
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      for (int i = 0; i < 3; i++) begin
        digit_q[i] <= digit_d[i];
      end
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign o_units    = digit_q[0];
  assign o_tens     = digit_q[1];
  assign o_hundreds = digit_q[2];
  assign o_running  = running_q;
  assign o_done     = done_q;
  assign o_zero     = zero_w;

endmodule
